csr_exec_ctrl: RTL and testbench

- Sequencer for the CSR execution path; sits between the CSR reservation station and the architectural CSR file.
- Queues issued CSR packets in order and holds each one until it is the oldest uncommitted instruction.
- Performs the read-modify-write on the CSR file, then broadcasts the completion tag (CSR_phy/CSR_done) to all reservation stations for wakeup.

---
 rtl/csr_exec_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_csr_exec_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_exec_ctrl.sv
// In-order sequencer for CSR read-modify-write ops: queues issued packets, waits for ROB head, then reads, writes and broadcasts.
// Latency: head match at N -> csr_re at N+1 -> csr_we at N+2 -> CSR_done at N+3; the FSM returns through IDLE between ops.
// Backpressure: none; the queue is sized to the reservation station, and a push into a full queue is dropped and flagged sticky.
module csr_exec_ctrl #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [129:0] in_pkt,
    input  logic         exception_sig,
    input  logic         mret_sig,
    input  logic         commit_head_valid,
    input  logic [31:0]  commit_inst_num,
    output logic         csr_re,
    output logic [11:0]  csr_rd_addr,
    input  logic [31:0]  csr_rd_data,
    output logic         csr_we,
    output logic [11:0]  csr_wr_addr,
    output logic [31:0]  csr_wr_data,
    output logic         CSR_done,
    output logic [7:0]   CSR_phy,
    output logic [31:0]  CSR_result,
    output logic         busy,
    output logic         overflow_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_HEAD,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    // Only the fields the sequencer needs; the operand mux is resolved at push time.
    typedef struct packed {
        logic [31:0] inst;
        logic [7:0]  rd;
        logic [3:0]  op;
        logic [31:0] src;
        logic [11:0] addr;
    } entry_t;

    localparam logic [PTR_W:0] L_DEPTH = (PTR_W + 1)'(DEPTH);

    state_t           r_state;
    state_t           w_state_nxt;
    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [31:0]      r_old;
    logic [7:0]       r_rd;
    logic             r_ovf;

    entry_t           w_in_ent;
    entry_t           w_head;
    logic             w_flush;
    logic             w_push_req;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_wr_en;
    logic [31:0]      w_new;
    logic             w_unused_op1;

    // operand1_phy is not used by the CSR path.
    assign w_unused_op1 = ^in_pkt[128:121];

    assign w_flush    = exception_sig | mret_sig;
    assign w_push_req = in_pkt[129];
    assign w_full     = (r_count == L_DEPTH);
    assign w_push     = w_push_req && !w_full;
    assign w_pop      = (r_state == S_DONE);
    assign w_head     = r_mem[r_rd_ptr];

    assign busy         = (r_count != '0) || (r_state != S_IDLE);
    assign overflow_err = r_ovf;

    // Unpack the issue packet into a queue entry, selecting the source operand.
    always_comb begin
        w_in_ent.inst = in_pkt[120:89];
        w_in_ent.rd   = in_pkt[88:81];
        w_in_ent.op   = in_pkt[80:77];
        w_in_ent.src  = in_pkt[76] ? in_pkt[31:0] : in_pkt[75:44];
        w_in_ent.addr = in_pkt[43:32];
    end

    // Queue storage: written at the tail on an accepted push.
    always_ff @(posedge clk) begin
        if (!reset && !w_flush && w_push) begin
            r_mem[r_wr_ptr] <= w_in_ent;
        end
    end

    // Queue pointers, occupancy and the sticky overflow flag; flush empties the queue but keeps the flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (PTR_W + 1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (PTR_W + 1)'(1);
            end
            if (w_push_req && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset || w_flush) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the old CSR value and destination during WRITE for the DONE broadcast.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_old <= '0;
            r_rd  <= '0;
        end else if (r_state == S_WRITE) begin
            r_old <= csr_rd_data;
            r_rd  <= w_head.rd;
        end
    end

    // Read-modify-write value; set/clear with a zero mask leave the CSR untouched.
    always_comb begin
        w_new   = '0;
        w_wr_en = 1'b0;
        case (w_head.op)
            4'd1: begin
                w_new   = w_head.src;
                w_wr_en = 1'b1;
            end
            4'd2: begin
                w_new   = csr_rd_data | w_head.src;
                w_wr_en = (w_head.src != '0);
            end
            4'd3: begin
                w_new   = csr_rd_data & ~w_head.src;
                w_wr_en = (w_head.src != '0);
            end
            default: begin
                w_new   = '0;
                w_wr_en = 1'b0;
            end
        endcase
    end

    // Next state and CSR-file / wakeup outputs; write and done are suppressed in a flush cycle.
    always_comb begin
        w_state_nxt = r_state;
        csr_re      = 1'b0;
        csr_rd_addr = '0;
        csr_we      = 1'b0;
        csr_wr_addr = '0;
        csr_wr_data = '0;
        CSR_done    = 1'b0;
        CSR_phy     = '0;
        CSR_result  = '0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_state_nxt = S_WAIT_HEAD;
                end
            end
            S_WAIT_HEAD: begin
                if (commit_head_valid && (commit_inst_num == w_head.inst)) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                csr_re      = 1'b1;
                csr_rd_addr = w_head.addr;
                w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                csr_we      = w_wr_en && !w_flush;
                csr_wr_addr = w_head.addr;
                csr_wr_data = w_new;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (!w_flush) begin
                    CSR_done   = 1'b1;
                    CSR_phy    = r_rd;
                    CSR_result = r_old;
                end
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_csr_exec_ctrl.sv
// Bench for csr_exec_ctrl: directed scenarios plus a randomized phase against a queue/timeline reference model.
// Each cycle drives inputs after the rising edge and checks every output on the falling edge.
// The CSR file is modelled in the bench and supplies read data in the cycle after the expected read.
module tb_csr_exec_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic [129:0] in_pkt;
    logic         exception_sig;
    logic         mret_sig;
    logic         commit_head_valid;
    logic [31:0]  commit_inst_num;
    logic         csr_re;
    logic [11:0]  csr_rd_addr;
    logic [31:0]  csr_rd_data;
    logic         csr_we;
    logic [11:0]  csr_wr_addr;
    logic [31:0]  csr_wr_data;
    logic         CSR_done;
    logic [7:0]   CSR_phy;
    logic [31:0]  CSR_result;
    logic         busy;
    logic         overflow_err;

    always #5 clk = ~clk;

    csr_exec_ctrl #(.DEPTH(16), .PTR_W(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_pkt            (in_pkt),
        .exception_sig     (exception_sig),
        .mret_sig          (mret_sig),
        .commit_head_valid (commit_head_valid),
        .commit_inst_num   (commit_inst_num),
        .csr_re            (csr_re),
        .csr_rd_addr       (csr_rd_addr),
        .csr_rd_data       (csr_rd_data),
        .csr_we            (csr_we),
        .csr_wr_addr       (csr_wr_addr),
        .csr_wr_data       (csr_wr_data),
        .CSR_done          (CSR_done),
        .CSR_phy           (CSR_phy),
        .CSR_result        (CSR_result),
        .busy              (busy),
        .overflow_err      (overflow_err)
    );

    typedef struct {
        logic [31:0] inst;
        logic [7:0]  rd;
        logic [3:0]  op;
        logic        src2;
        logic [31:0] cdata;
        logic [11:0] addr;
        logic [31:0] imm;
        int          push_t;
    } op_t;

    // Reference model: pending ops in order, architectural CSR contents, and the timeline of the op in flight.
    op_t         q[$];
    logic [31:0] mem [4096];
    int          t;
    int          m;
    int          last_idle;
    bit          inflight;
    bit          ovf_m;
    logic [31:0] old_m;
    logic [31:0] next_inst;

    int checks;
    int errors;
    int n_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, t);
        end
    endtask

    function automatic logic [129:0] mk(input op_t o);
        logic [7:0] op1;
        op1 = 8'($urandom);
        return {1'b1, op1, o.inst, o.rd, o.op, o.src2, o.cdata, o.addr, o.imm};
    endfunction

    function automatic logic [129:0] nop();
        logic [129:0] p;
        p = {2'b00, $urandom(), $urandom(), $urandom(), $urandom()};
        p[129] = 1'b0;
        return p;
    endfunction

    function automatic op_t rnd_op();
        op_t o;
        o.inst   = next_inst;
        next_inst = next_inst + 32'd1;
        o.rd     = 8'($urandom);
        o.op     = 4'($urandom_range(0, 5));
        o.src2   = 1'($urandom);
        o.cdata  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
        o.imm    = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
        o.addr   = 12'h300 + 12'($urandom_range(0, 3));
        o.push_t = 0;
        return o;
    endfunction

    function automatic op_t dir_op(input logic [31:0] inst, input logic [7:0] rd, input logic [3:0] op,
                                   input logic src2, input logic [31:0] cdata, input logic [11:0] addr,
                                   input logic [31:0] imm);
        op_t o;
        o.inst = inst; o.rd = rd; o.op = op; o.src2 = src2;
        o.cdata = cdata; o.addr = addr; o.imm = imm; o.push_t = 0;
        return o;
    endfunction

    function automatic logic [31:0] head_inst();
        return (q.size() > 0) ? q[0].inst : $urandom();
    endfunction

    // One clock cycle: drive, check on the falling edge, then advance the model across the rising edge.
    task automatic step(input logic [129:0] pkt, input bit fl, input bit chv, input logic [31:0] ci);
        op_t         h;
        op_t         n;
        bit          wr_cyc;
        bit          e_re;
        bit          e_we;
        bit          e_done;
        logic [31:0] src;
        logic [31:0] newv;
        logic [31:0] old;
        in_pkt            = pkt;
        exception_sig     = 1'b0;
        mret_sig          = 1'b0;
        if (fl) begin
            if ($urandom_range(0, 1) == 0) exception_sig = 1'b1;
            else                           mret_sig      = 1'b1;
        end
        commit_head_valid = chv;
        commit_inst_num   = ci;
        h = '{default: '0};
        if (q.size() > 0) h = q[0];
        wr_cyc      = inflight && (t == m + 2);
        csr_rd_data = wr_cyc ? mem[h.addr] : $urandom();
        #4;
        e_re   = inflight && (t == m + 1);
        e_we   = 1'b0;
        newv   = '0;
        old    = '0;
        if (wr_cyc) begin
            old = mem[h.addr];
            src = h.src2 ? h.imm : h.cdata;
            case (h.op)
                4'd1: begin newv = src;        e_we = 1'b1;        end
                4'd2: begin newv = old | src;  e_we = (src != 0);  end
                4'd3: begin newv = old & ~src; e_we = (src != 0);  end
                default: begin newv = '0;      e_we = 1'b0;        end
            endcase
            if (fl) e_we = 1'b0;
        end
        e_done = inflight && (t == m + 3) && !fl;

        chk("csr_re", 32'(csr_re), 32'(e_re));
        if (e_re) chk("csr_rd_addr", 32'(csr_rd_addr), 32'(h.addr));
        chk("csr_we", 32'(csr_we), 32'(e_we));
        if (e_we) begin
            chk("csr_wr_addr", 32'(csr_wr_addr), 32'(h.addr));
            chk("csr_wr_data", csr_wr_data, newv);
        end
        chk("CSR_done", 32'(CSR_done), 32'(e_done));
        chk("CSR_phy", 32'(CSR_phy), e_done ? 32'(h.rd) : 32'h0);
        chk("CSR_result", CSR_result, e_done ? old_m : 32'h0);
        chk("busy", 32'(busy), 32'(q.size() != 0));
        chk("overflow_err", 32'(overflow_err), 32'(ovf_m));
        if (CSR_done) n_done++;

        if (fl) begin
            q.delete();
            inflight  = 1'b0;
            last_idle = t;
        end else begin
            if (wr_cyc) begin
                old_m = old;
                if (e_we) mem[h.addr] = newv;
            end
            if (!inflight && q.size() > 0 && chv && ci == q[0].inst &&
                t >= last_idle + 2 && t >= q[0].push_t + 2) begin
                inflight = 1'b1;
                m        = t;
            end
            if (pkt[129]) begin
                if (q.size() >= 16) begin
                    ovf_m = 1'b1;
                end else begin
                    n.inst  = pkt[120:89];
                    n.rd    = pkt[88:81];
                    n.op    = pkt[80:77];
                    n.src2  = pkt[76];
                    n.cdata = pkt[75:44];
                    n.addr  = pkt[43:32];
                    n.imm   = pkt[31:0];
                    n.push_t = t;
                    q.push_back(n);
                end
            end
            if (e_done) begin
                void'(q.pop_front());
                inflight  = 1'b0;
                last_idle = t;
            end
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(nop(), 1'b0, 1'b1, head_inst());
    endtask

    initial begin
        int  d0;
        bit  hit;
        checks    = 0;
        errors    = 0;
        n_done    = 0;
        inflight  = 1'b0;
        ovf_m     = 1'b0;
        old_m     = '0;
        m         = 0;
        next_inst = 32'd100;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom();

        reset             = 1'b1;
        in_pkt            = nop();
        exception_sig     = 1'b0;
        mret_sig          = 1'b0;
        commit_head_valid = 1'b0;
        commit_inst_num   = '0;
        csr_rd_data       = '0;
        repeat (3) @(posedge clk);
        #1;
        reset     = 1'b0;
        t         = 0;
        last_idle = -1;
        idle(2);

        // CSRRW: write 0x88 to 0x300, old value 0x1800 returned to Rd 0x12.
        mem[12'h300] = 32'h0000_1800;
        step(mk(dir_op(32'd5, 8'h12, 4'd1, 1'b0, 32'h88, 12'h300, $urandom())), 1'b0, 1'b1, 32'd5);
        for (int i = 0; i < 8; i++) step(nop(), 1'b0, 1'b1, 32'd5);

        // CSRRS with zero immediate: read only; then CSRRC 0x8 on 0xF gives 0x7.
        mem[12'h305] = 32'h0000_0ABC;
        step(mk(dir_op(32'd7, 8'h21, 4'd2, 1'b1, $urandom(), 12'h305, 32'h0)), 1'b0, 1'b1, 32'd7);
        for (int i = 0; i < 8; i++) step(nop(), 1'b0, 1'b1, 32'd7);
        mem[12'h340] = 32'h0000_000F;
        step(mk(dir_op(32'd8, 8'h22, 4'd3, 1'b0, 32'h8, 12'h340, $urandom())), 1'b0, 1'b1, 32'd8);
        for (int i = 0; i < 8; i++) step(nop(), 1'b0, 1'b1, 32'd8);

        // In-order: younger op 4 is committed first and must wait behind op 3.
        step(mk(dir_op(32'd3, 8'h33, 4'd1, 1'b1, 32'h0, 12'h301, 32'h5A5A)), 1'b0, 1'b1, 32'd4);
        step(mk(dir_op(32'd4, 8'h44, 4'd2, 1'b0, 32'h10, 12'h301, 32'h0)), 1'b0, 1'b1, 32'd4);
        for (int i = 0; i < 6; i++) step(nop(), 1'b0, 1'b1, 32'd4);
        d0 = n_done;
        idle(16);
        chk("inorder_done_count", 32'(n_done - d0), 32'd2);

        // Flush in the WRITE cycle: no write, no done, queue emptied.
        step(mk(dir_op(32'd9, 8'h55, 4'd1, 1'b0, 32'hDEAD, 12'h302, 32'h0)), 1'b0, 1'b1, 32'd9);
        hit = 1'b0;
        d0  = n_done;
        for (int i = 0; i < 12 && !hit; i++) begin
            if (inflight && t == m + 2) begin
                step(nop(), 1'b1, 1'b1, head_inst());
                hit = 1'b1;
            end else begin
                step(nop(), 1'b0, 1'b1, head_inst());
            end
        end
        chk("flush_reached_write", 32'(hit), 32'd1);
        idle(4);
        chk("flush_no_done", 32'(n_done - d0), 32'd0);

        // Fill 17 with commit held off: one overflow, then 16 in-order completions across the wrap.
        for (int i = 0; i < 17; i++) step(mk(rnd_op()), 1'b0, 1'b0, $urandom());
        d0 = n_done;
        idle(95);
        chk("fill_done_count", 32'(n_done - d0), 32'd16);

        // Push in the DONE cycle: the new entry is served next.
        step(mk(rnd_op()), 1'b0, 1'b1, head_inst());
        hit = 1'b0;
        d0  = n_done;
        for (int i = 0; i < 12 && !hit; i++) begin
            if (inflight && t == m + 3) begin
                step(mk(rnd_op()), 1'b0, 1'b1, head_inst());
                hit = 1'b1;
            end else begin
                step(nop(), 1'b0, 1'b1, head_inst());
            end
        end
        chk("push_pop_reached_done", 32'(hit), 32'd1);
        idle(12);
        chk("push_pop_done_count", 32'(n_done - d0), 32'd2);

        // Randomized traffic with sporadic commit stalls, wrong commit numbers and flushes.
        for (int i = 0; i < 400; i++) begin
            logic [129:0] p;
            logic [31:0]  ci;
            p  = ($urandom_range(0, 3) == 0 && q.size() < 12) ? mk(rnd_op()) : nop();
            ci = ($urandom_range(0, 7) == 0) ? $urandom() : head_inst();
            step(p, ($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0), ci);
        end
        idle(80);
        chk("drained", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
